// File: rtl/mem_exception_sequencer.sv
// MEM-stage sequencer for a multi-cycle data memory: issues registered strobes, stalls the
// pipeline while busy, and raises a held trap request on ALU faults, conflicting requests or timeout.

module mem_exception_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ALU_status,
  input  logic              readIn,
  input  logic              writeIn,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_ready,
  input  logic              exc_ack,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              stall,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] epc,
  output logic [3:0]        cause
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    EXC    = 2'd2
  } state_t;

  localparam logic [7:0] LAST_COUNT    = 8'(TIMEOUT - 1);
  localparam logic [3:0] CAUSE_NONE    = 4'd0;
  localparam logic [3:0] CAUSE_OVF     = 4'd1;
  localparam logic [3:0] CAUSE_ALIGN   = 4'd2;
  localparam logic [3:0] CAUSE_RANGE   = 4'd3;
  localparam logic [3:0] CAUSE_TIMEOUT = 4'd4;
  localparam logic [3:0] CAUSE_RDWR    = 4'd5;

  state_t     state_r;
  logic [7:0] counter_r;
  logic       excDet_s;
  logic       reqDet_s;
  logic [3:0] trapCode_s;
  logic       trapNow_s;

  // Highest-priority fault seen in IDLE; timeout is raised separately from ACCESS.
  function automatic logic [3:0] faultCause(input logic [7:0] status, input logic rd, input logic wr);
    logic [3:0] code;
    if (status[6]) begin
      code = CAUSE_OVF;
    end else if (status[3]) begin
      code = CAUSE_ALIGN;
    end else if (status[2]) begin
      code = CAUSE_RANGE;
    end else if (rd && wr) begin
      code = CAUSE_RDWR;
    end else begin
      code = CAUSE_NONE;
    end
    return code;
  endfunction

  // Fault/request decode and the combinational stall, so the requester freezes in the same cycle.
  always_comb begin
    excDet_s   = ALU_status[6] | ALU_status[3] | ALU_status[2];
    reqDet_s   = readIn | writeIn;
    trapCode_s = faultCause(ALU_status, readIn, writeIn);
    trapNow_s  = (trapCode_s != CAUSE_NONE);
    stall      = (state_r != IDLE) | excDet_s | reqDet_s;
  end

  // Sequencer FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      counter_r <= 8'd0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      exc_valid <= 1'b0;
      epc       <= '0;
      cause     <= CAUSE_NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trapNow_s) begin
            state_r   <= EXC;
            exc_valid <= 1'b1;
            epc       <= pc_in;
            cause     <= trapCode_s;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
          end else if (reqDet_s) begin
            state_r   <= ACCESS;
            MemRead   <= readIn;
            MemWrite  <= writeIn;
            counter_r <= 8'd0;
          end else begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
          end
        end
        ACCESS: begin
          // A ready on the final counted cycle still completes normally.
          if (mem_ready) begin
            state_r   <= IDLE;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            counter_r <= 8'd0;
          end else if (counter_r == LAST_COUNT) begin
            state_r   <= EXC;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            exc_valid <= 1'b1;
            epc       <= pc_in;
            cause     <= CAUSE_TIMEOUT;
            counter_r <= 8'd0;
          end else begin
            counter_r <= counter_r + 8'd1;
          end
        end
        EXC: begin
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (exc_ack) begin
            state_r   <= IDLE;
            exc_valid <= 1'b0;
          end else begin
            exc_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          counter_r <= 8'd0;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b0;
          exc_valid <= 1'b0;
        end
      endcase
    end
  end

  mem_exception_sequencer_chk #(
    .TIMEOUT(TIMEOUT)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .exc_valid(exc_valid),
    .counter  (counter_r)
  );

endmodule

// Safety invariants of the sequencer outputs, kept apart from the datapath.
module mem_exception_sequencer_chk #(
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       reset,
  input logic       MemRead,
  input logic       MemWrite,
  input logic       exc_valid,
  input logic [7:0] counter
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  a_strobeExclusive: assert property (@(posedge clk) disable iff (reset)
    !(MemRead && MemWrite));

  a_noStrobeInTrap: assert property (@(posedge clk) disable iff (reset)
    !(exc_valid && (MemRead || MemWrite)));

  a_counterBound: assert property (@(posedge clk) disable iff (reset)
    counter <= LAST_COUNT);

endmodule
